fault_monitor_mc: RTL

//  Multi-channel successor to the single-rail fault detector: NCH independent volt/current monitors.

---
 rtl/fault_mon_pkg.sv | 27 ++
 rtl/fault_mon_chan.sv | 110 +++++++++++
 rtl/fault_monitor_mc.sv | 65 ++++++
 3 files changed

// File: rtl/fault_mon_pkg.sv
// Shared types and helpers for the multi-channel fault monitor.
// Optional feature macro: FAULT_MON_CLR_EN (adds per-channel clr).
package fault_mon_pkg;

    typedef enum logic [1:0] {
        NORM  = 2'd0,
        WARN  = 2'd1,
        FAULT = 2'd2,
        SHDN  = 2'd3
    } state_t;

    localparam int CAUSE_OV = 2;
    localparam int CAUSE_UV = 1;
    localparam int CAUSE_OC = 0;

    // Maps fp32 onto an unsigned key with the same ordering; -0 folds to +0.
    function automatic logic [31:0] fp32_key(input logic [31:0] x);
        logic [31:0] v;
        v = (x == 32'h8000_0000) ? 32'h0 : x;
        return v[31] ? ~v : (v | 32'h8000_0000);
    endfunction

    function automatic logic fp32_is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
    endfunction

endpackage

// File: rtl/fault_mon_chan.sv
// One monitored channel: fp32 compares, escalation FSM, counter, cause.
// Ports: clk, rstn, volt/current samples, ov/uv/oc thresholds,
// clr (only with FAULT_MON_CLR_EN), warning/fault/shutdown, cause.
module fault_mon_chan
    import fault_mon_pkg::*;
#(
    parameter int FAULT_CNT = 3,
    parameter int SHDN_DLY  = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] volt,
    input  logic [31:0] current,
    input  logic [31:0] ov_thr,
    input  logic [31:0] uv_thr,
    input  logic [31:0] oc_thr,
`ifdef FAULT_MON_CLR_EN
    input  logic        clr,
`endif
    output logic        warning,
    output logic        fault,
    output logic        shutdown,
    output logic [2:0]  cause
);

    localparam int CW = $clog2(FAULT_CNT + SHDN_DLY + 1);
    localparam logic [CW-1:0] CNT_F = CW'(FAULT_CNT);
    localparam logic [CW-1:0] CNT_S = CW'(FAULT_CNT + SHDN_DLY);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic [2:0]    cause_n, smp;
    logic          nan_v, abn;

    always_comb begin
        nan_v         = fp32_is_nan(volt);
        smp           = 3'b000;
        smp[CAUSE_OV] = nan_v | (fp32_key(volt) > fp32_key(ov_thr));
        smp[CAUSE_UV] = nan_v | (fp32_key(volt) < fp32_key(uv_thr));
        smp[CAUSE_OC] = fp32_is_nan(current)
                      | (fp32_key(current) > fp32_key(oc_thr));
        abn           = |smp;
        cnt_inc       = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cause_n = cause;
        unique case (state)
            NORM: begin
                if (abn) begin
                    cnt_n = CW'(1);
                    if (FAULT_CNT == 1) begin
                        state_n = FAULT;
                        cause_n = smp;
                    end else begin
                        state_n = WARN;
                    end
                end
            end
            WARN: begin
                if (abn) begin
                    cnt_n = cnt_inc;
                    if (cnt_inc >= CNT_F) begin
                        state_n = FAULT;
                        cause_n = smp;
                    end
                end else begin
                    state_n = NORM;
                    cnt_n   = '0;
                end
            end
            FAULT: begin
                // cnt entered at FAULT_CNT, so SHDN lands SHDN_DLY edges later
                cnt_n = cnt_inc;
                if (cnt_inc >= CNT_S) state_n = SHDN;
            end
            SHDN: begin
`ifdef FAULT_MON_CLR_EN
                if (clr && !abn) begin
                    state_n = NORM;
                    cnt_n   = '0;
                    cause_n = 3'b000;
                end
`endif
            end
            default: state_n = NORM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= NORM;
            cnt      <= '0;
            cause    <= 3'b000;
            warning  <= 1'b0;
            fault    <= 1'b0;
            shutdown <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            cause    <= cause_n;
            warning  <= (state_n == WARN) || (state_n == FAULT);
            fault    <= (state_n == FAULT) || (state_n == SHDN);
            shutdown <= (state_n == SHDN);
        end
    end

endmodule

// File: rtl/fault_monitor_mc.sv
// NCH independent fp32 volt/current fault monitors with global flags.
// Ports: per-channel packed samples/thresholds, clr (FAULT_MON_CLR_EN),
// per-channel warning/fault/shutdown/cause, registered *_any flags.
module fault_monitor_mc
    import fault_mon_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int FAULT_CNT = 3,
    parameter int SHDN_DLY  = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [32*NCH-1:0] volt,
    input  logic [32*NCH-1:0] current,
    input  logic [32*NCH-1:0] ov_thr,
    input  logic [32*NCH-1:0] uv_thr,
    input  logic [32*NCH-1:0] oc_thr,
`ifdef FAULT_MON_CLR_EN
    input  logic [NCH-1:0]    clr,
`endif
    output logic [NCH-1:0]    warning,
    output logic [NCH-1:0]    fault,
    output logic [NCH-1:0]    shutdown,
    output logic [3*NCH-1:0]  cause,
    output logic              warning_any,
    output logic              fault_any,
    output logic              shutdown_any
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        fault_mon_chan #(
            .FAULT_CNT(FAULT_CNT),
            .SHDN_DLY (SHDN_DLY)
        ) u_chan (
            .clk     (clk),
            .rstn    (rstn),
            .volt    (volt[32*i +: 32]),
            .current (current[32*i +: 32]),
            .ov_thr  (ov_thr[32*i +: 32]),
            .uv_thr  (uv_thr[32*i +: 32]),
            .oc_thr  (oc_thr[32*i +: 32]),
`ifdef FAULT_MON_CLR_EN
            .clr     (clr[i]),
`endif
            .warning (warning[i]),
            .fault   (fault[i]),
            .shutdown(shutdown[i]),
            .cause   (cause[3*i +: 3])
        );
    end

    // Reduced from the registered per-channel outputs, hence one cycle later
    always_ff @(posedge clk) begin
        if (!rstn) begin
            warning_any  <= 1'b0;
            fault_any    <= 1'b0;
            shutdown_any <= 1'b0;
        end else begin
            warning_any  <= |warning;
            fault_any    <= |fault;
            shutdown_any <= |shutdown;
        end
    end

endmodule
